// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: datapath widths and the instruction-memory
// arbiter state and read-owner encodings.
package riscv_pkg;

  localparam int unsigned CPU_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH = 10;

  typedef enum logic {
    FETCH_PRI,
    LOAD_BURST
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_F,
    OWN_L
  } owner_e;

endpackage

// File: rtl/imem_rd_return.sv
// Tracks which requester owns the read issued last cycle and steers the
// one-cycle-late memory data to that requester only.
module imem_rd_return
  import riscv_pkg::*;
#(
  parameter int unsigned CPU_WIDTH = riscv_pkg::CPU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_rd,
  input  logic                 l_rd,
  input  logic [CPU_WIDTH-1:0] mem_rdata,
  output logic                 f_rvalid,
  output logic [CPU_WIDTH-1:0] f_rdata,
  output logic                 l_rvalid,
  output logic [CPU_WIDTH-1:0] l_rdata
);

  owner_e rd_owner_q, rd_owner_d;

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (f_rd) begin
      rd_owner_d = OWN_F;
    end else if (l_rd) begin
      rd_owner_d = OWN_L;
    end
  end

  // Reset drops any in-flight read so no stale rvalid appears after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign f_rvalid = (rd_owner_q == OWN_F);
  assign l_rvalid = (rd_owner_q == OWN_L);
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one single-port instruction memory between CPU fetch (read-only, default
// priority) and the loader/debug port, with anti-starvation wait and bounded bursts.
module imem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned CPU_WIDTH  = riscv_pkg::CPU_WIDTH,
  parameter int unsigned ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [CPU_WIDTH-1:0]  f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [CPU_WIDTH-1:0]  l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [CPU_WIDTH-1:0]  l_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [CPU_WIDTH-1:0]  mem_wdata,
  input  logic [CPU_WIDTH-1:0]  mem_rdata,
  output logic                  l_starved
);

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);

  arb_state_e state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] burst_q, burst_d;
  logic       f_win, l_win;

  assign l_starved = (wait_q == MAX_WAIT_C);

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    f_win   = 1'b0;
    l_win   = 1'b0;
    unique case (state_q)
      FETCH_PRI: begin
        if (l_req && (!f_req || l_starved)) begin
          l_win   = 1'b1;
          burst_d = 8'd1;
          state_d = LOAD_BURST;
        end else begin
          f_win = f_req;
        end
      end
      LOAD_BURST: begin
        if (l_req && (burst_q < BURST_LEN_C)) begin
          l_win   = 1'b1;
          burst_d = burst_q + 8'd1;
        end else if (!l_req || f_req) begin
          state_d = FETCH_PRI;
          f_win   = f_req;
        end else begin
          // Burst cap reached but fetch is idle: keep the loader going.
          l_win = 1'b1;
        end
      end
      default: state_d = FETCH_PRI;
    endcase

    wait_d = wait_q;
    if (l_win) begin
      wait_d = 4'd0;
    end else if (l_req && !l_starved) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH_PRI;
      wait_q  <= 4'd0;
      burst_q <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
    end
  end

  // Grants are forced low for the whole time reset is asserted.
  assign f_gnt     = f_win & rst;
  assign l_gnt     = l_win & rst;
  assign mem_en    = f_gnt | l_gnt;
  assign mem_we    = l_gnt & l_we;
  assign mem_addr  = l_gnt ? l_addr : (f_gnt ? f_addr : '0);
  assign mem_wdata = l_gnt ? l_wdata : '0;

  imem_rd_return #(
    .CPU_WIDTH(CPU_WIDTH)
  ) u_rd_return (
    .clk      (clk),
    .rst      (rst),
    .f_rd     (f_gnt),
    .l_rd     (l_gnt & ~l_we),
    .mem_rdata(mem_rdata),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata)
  );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a write-first synchronous memory model.
module tb_imem_port_arbiter;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [9:0]  f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        l_req;
  logic        l_we;
  logic [9:0]  l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        l_starved;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  int vectors;
  int miscompares;

  imem_port_arbiter #(
    .CPU_WIDTH (32),
    .ADDR_WIDTH(10),
    .MAX_WAIT  (4),
    .BURST_LEN (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .l_req    (l_req),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_gnt    (l_gnt),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .l_starved(l_starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req   = 1'b0;
    f_addr  = '0;
    l_req   = 1'b0;
    l_we    = 1'b0;
    l_addr  = '0;
    l_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    f_req = 1'b1;
    l_req = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    vectors++;
    if ({f_gnt, l_gnt, mem_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_gnt: got f/l/en=%b expected 000", {f_gnt, l_gnt, mem_en});
    end
    vectors++;
    if ({f_rvalid, l_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_rvalid: got f/l=%b expected 00", {f_rvalid, l_rvalid});
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({f_gnt, l_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_release_gnt: got f/l=%b expected 10", {f_gnt, l_gnt});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_fetch_only();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      pre_we   = 1'b1;
      pre_addr = 10'(i);
      pre_data = 32'h13 + 32'(i);
      tick();
    end
    pre_we = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      f_req  = (k < 4);
      f_addr = 10'(k);
      @(negedge clk);
      if (k < 4) begin
        vectors++;
        if (f_gnt !== 1'b1 || mem_addr !== 10'(k)) begin
          miscompares++;
          $display("FAIL fetch_gnt[%0d]: got gnt=%b addr=%h expected 1 %h", k, f_gnt, mem_addr,
                   10'(k));
        end
      end
      if (k > 0) begin
        vectors++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'h13 + 32'(k - 1)) begin
          miscompares++;
          $display("FAIL fetch_rdata[%0d]: got v=%b d=%h expected 1 %h", k, f_rvalid, f_rdata,
                   32'h13 + 32'(k - 1));
        end
      end
      vectors++;
      if (l_rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_l_rvalid[%0d]: got %b expected 0", k, l_rvalid);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (f_rvalid !== 1'b0 || f_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL fetch_drain: got v=%b d=%h expected 0 0", f_rvalid, f_rdata);
    end
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    f_req  = 1'b1;
    f_addr = 10'h0;
    l_req  = 1'b1;
    l_we   = 1'b0;
    l_addr = 10'h2;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if ({l_gnt, f_gnt, l_starved} !== 3'b010) begin
        miscompares++;
        $display("FAIL starve_wait[%0d]: got l/f/starved=%b expected 010", c,
                 {l_gnt, f_gnt, l_starved});
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if ({l_gnt, f_gnt, l_starved} !== 3'b101) begin
      miscompares++;
      $display("FAIL starve_force: got l/f/starved=%b expected 101", {l_gnt, f_gnt, l_starved});
    end
    tick();
    l_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (l_starved !== 1'b0 || dut.wait_q !== 4'd0) begin
      miscompares++;
      $display("FAIL starve_clear: got starved=%b wait=%0d expected 0 0", l_starved, dut.wait_q);
    end
    vectors++;
    if (l_rvalid !== 1'b1 || l_rdata !== 32'h15 || f_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_rdata: got v=%b d=%h fgnt=%b expected 1 00000015 1", l_rvalid,
               l_rdata, f_gnt);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_burst_cap();
    do_reset();
    l_req = 1'b1;
    l_we  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f_req   = (i > 0);
      f_addr  = 10'h5;
      l_addr  = 10'h100 + 10'(i);
      l_wdata = 32'hA5A5_0000 + 32'(i);
      @(negedge clk);
      vectors++;
      if ({l_gnt, f_gnt, mem_we} !== 3'b101 || mem_addr !== 10'h100 + 10'(i)) begin
        miscompares++;
        $display("FAIL burst_l_gnt[%0d]: got l/f/we=%b addr=%h expected 101 %h", i,
                 {l_gnt, f_gnt, mem_we}, mem_addr, 10'h100 + 10'(i));
      end
      tick();
    end
    l_addr  = 10'h108;
    l_wdata = 32'hA5A5_0008;
    @(negedge clk);
    vectors++;
    if ({l_gnt, f_gnt} !== 2'b01 || mem_addr !== 10'h5) begin
      miscompares++;
      $display("FAIL burst_cap_handover: got l/f=%b addr=%h expected 01 005", {l_gnt, f_gnt},
               mem_addr);
    end
    tick();
    idle_inputs();
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (mem[10'h100 + 10'(i)] !== 32'hA5A5_0000 + 32'(i)) begin
        miscompares++;
        $display("FAIL burst_mem[%0d]: got %h expected %h", i, mem[10'h100 + 10'(i)],
                 32'hA5A5_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_burst_idle();
    int gnts;
    gnts = 0;
    do_reset();
    l_req  = 1'b1;
    l_we   = 1'b0;
    l_addr = 10'h1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (l_gnt === 1'b1) gnts++;
      tick();
    end
    vectors++;
    if (gnts !== 12) begin
      miscompares++;
      $display("FAIL burst_idle_count: got %0d grants expected 12", gnts);
    end
    vectors++;
    if (dut.state_q !== LOAD_BURST) begin
      miscompares++;
      $display("FAIL burst_idle_state: got %0d expected %0d", dut.state_q, LOAD_BURST);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_raw_and_reset();
    do_reset();
    l_req   = 1'b1;
    l_we    = 1'b1;
    l_addr  = 10'h20;
    l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if (l_gnt !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL raw_write: got gnt=%b wdata=%h expected 1 deadbeef", l_gnt, mem_wdata);
    end
    tick();
    l_we = 1'b0;
    @(negedge clk);
    vectors++;
    if (l_gnt !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_read_gnt: got gnt=%b we=%b expected 1 0", l_gnt, mem_we);
    end
    tick();
    l_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (l_rvalid !== 1'b1 || l_rdata !== 32'hDEAD_BEEF || f_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_rdata: got v=%b d=%h fv=%b expected 1 deadbeef 0", l_rvalid, l_rdata,
               f_rvalid);
    end
    tick();
    l_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (l_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midrd_gnt: got %b expected 1", l_gnt);
    end
    tick();
    rst   = 1'b0;
    l_req = 1'b0;
    #1;
    vectors++;
    if (l_rvalid !== 1'b0 || l_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midrd_drop: got v=%b d=%h expected 0 0", l_rvalid, l_rdata);
    end
    repeat (2) tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({l_rvalid, f_rvalid} !== 2'b00) begin
        miscompares++;
        $display("FAIL midrd_after[%0d]: got l/f rvalid=%b expected 00", c, {l_rvalid, f_rvalid});
      end
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pre_we      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    rst         = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_starvation();
    test_burst_cap();
    test_burst_idle();
    test_raw_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
